// File: rtl/dar_prgrm_serializer.sv
// Serializer feeding the audio router's programming port with bounded retry.
// Optional trailing even-parity bit is enabled with DAR_PRGRM_PARITY_EN.
module dar_prgrm_serializer #(
  parameter int unsigned PRGM_BITS    = 8,
  parameter int unsigned CHECK_CYCLES = 2,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic [PRGM_BITS-1:0] cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic                 prgrm_in,
  output logic                 prgrm_go_,
  input  logic                 err_,
  output logic                 busy,
  output logic                 done,
  output logic                 fail
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    GAP
  } state_t;

`ifdef DAR_PRGRM_PARITY_EN
  localparam int unsigned FRAME = PRGM_BITS + 1;
`else
  localparam int unsigned FRAME = PRGM_BITS;
`endif
  localparam int unsigned CW = 6;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           retry_q, retry_d;
  logic [PRGM_BITS-1:0] shadow_q, shadow_d;
  logic [PRGM_BITS-1:0] sh_q, sh_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;
  logic                 in_q, in_d;
  logic                 go_q, go_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic                 err_hit;
`ifdef DAR_PRGRM_PARITY_EN
  logic                 par_q, par_d;
`endif

  // Next-state and registered-output decode for the frame sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    shadow_d = shadow_q;
    sh_d     = sh_q;
    err_d    = err_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    in_d     = 1'b0;
    go_d     = 1'b1;
    done_d   = 1'b0;
    fail_d   = 1'b0;
    err_hit  = 1'b0;
`ifdef DAR_PRGRM_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (cfg_valid && ready_q) begin
          shadow_d = cfg_data;
          sh_d     = cfg_data;
          retry_d  = '0;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
`ifdef DAR_PRGRM_PARITY_EN
          par_d    = ^cfg_data;
`endif
        end
      end
      SHIFT: begin
        go_d  = 1'b0;
        in_d  = sh_q[PRGM_BITS-1];
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CW'(1);
`ifdef DAR_PRGRM_PARITY_EN
        if (cnt_q == CW'(PRGM_BITS)) in_d = par_q;
`endif
        if (cnt_q == CW'(FRAME - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // First CHECK edge only raises the strobe; err_ is sampled after.
        err_hit = err_q | ((cnt_q != '0) & ~err_);
        err_d   = err_hit;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(CHECK_CYCLES)) begin
          if (!err_hit) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (retry_q < 3'(MAX_RETRY)) begin
            retry_d = retry_q + 3'd1;
            state_d = GAP;
          end else begin
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        sh_d    = shadow_q;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      shadow_q <= '0;
      sh_q     <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      in_q     <= 1'b0;
      go_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
`ifdef DAR_PRGRM_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      shadow_q <= shadow_d;
      sh_q     <= sh_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      in_q     <= in_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
`ifdef DAR_PRGRM_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign cfg_ready = ready_q;
  assign prgrm_in  = in_q;
  assign prgrm_go_ = go_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_dar_prgrm_serializer.sv
// Directed bench for dar_prgrm_serializer (default parameters).
// Parity cases are exercised when DAR_PRGRM_PARITY_EN is defined.
module tb_dar_prgrm_serializer;

`ifdef DAR_PRGRM_PARITY_EN
  localparam int FRAME     = 9;
  localparam int DONE_EDGE = 12;
`else
  localparam int FRAME     = 8;
  localparam int DONE_EDGE = 11;
`endif

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic       prgrm_in;
  logic       prgrm_go_;
  logic       err_ = 1'b1;
  logic       busy;
  logic       done;
  logic       fail;

  int checks = 0;
  int failures = 0;

  dar_prgrm_serializer dut (
    .clk       (clk),
    .rst_      (rst_),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .prgrm_in  (prgrm_in),
    .prgrm_go_ (prgrm_go_),
    .err_      (err_),
    .busy      (busy),
    .done      (done),
    .fail      (fail)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] bits;
    logic       par;
    int         done_edge;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a word and take the accept edge (E0).
  task automatic accept(input logic [7:0] d);
    for (int i = 0; i < 10; i++) begin
      if (cfg_ready) break;
      tick();
    end
    chk("accept_ready", cfg_ready, 1);
    cfg_data = d;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_data = ~d;
    chk("accept_busy", busy, 1);
    chk("accept_ready_low", cfg_ready, 0);
  endtask

  // Checks one frame from its first bit edge up to the strobe rising.
  task automatic frame(input logic [7:0] d, input string nm);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk({nm, "_go_low"}, prgrm_go_, 0);
      chk({nm, "_bit"}, prgrm_in, d[7-k]);
    end
`ifdef DAR_PRGRM_PARITY_EN
    tick();
    chk({nm, "_par_go_low"}, prgrm_go_, 0);
    chk({nm, "_par_bit"}, prgrm_in, ^d);
`endif
    tick();
    chk({nm, "_go_high"}, prgrm_go_, 1);
    chk({nm, "_in_zero"}, prgrm_in, 0);
  endtask

  // Error-free word: serial bits and done-edge latency.
  task automatic run_word(input vec_t v);
    logic [8:0] seq;
    int         de;
    seq = {v.bits, v.par};
    de = -1;
    accept(v.data);
    for (int e = 1; e <= 30; e++) begin
      tick();
      chk("run_fail_low", fail, 0);
      if (e <= FRAME) begin
        chk("run_go_low", prgrm_go_, 0);
        chk("run_bit", prgrm_in, seq[9-e]);
      end else begin
        chk("run_go_high", prgrm_go_, 1);
      end
      if (done) begin
        de = e;
        chk("run_busy_fall", busy, 0);
        break;
      end
      chk("run_busy_hold", busy, 1);
    end
    chk("run_done_edge", de, v.done_edge);
    tick();
    chk("run_done_single", done, 0);
    chk("run_ready_back", cfg_ready, 1);
  endtask

  initial begin
    int frames;
    int dones;
    int fails;
    logic go_prev;

    vecs[0] = '{8'hB4, 8'b1011_0100, 1'b0, DONE_EDGE};
    vecs[1] = '{8'h3C, 8'b0011_1100, 1'b0, DONE_EDGE};
    vecs[2] = '{8'h80, 8'b1000_0000, 1'b1, DONE_EDGE};
    vecs[3] = '{8'h07, 8'b0000_0111, 1'b1, DONE_EDGE};
    vecs[4] = '{8'hA5, 8'b1010_0101, 1'b0, DONE_EDGE};

    // Reset behaviour and release.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_go", prgrm_go_, 1);
      chk("rst_in", prgrm_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cfg_ready, 0);
    end
    rst_ = 1'b1;
    chk("release_ready_low", cfg_ready, 0);
    tick();
    chk("release_ready_high", cfg_ready, 1);
    chk("release_done", done, 0);

    // Table of error-free words.
    for (int i = 0; i < 5; i++) run_word(vecs[i]);

    // Single error in first CHECK cycle of frame 1 -> one retry.
    accept(8'h3C);
    frame(8'h3C, "r1");
    err_ = 1'b0;
    tick();
    err_ = 1'b1;
    chk("r_check_go", prgrm_go_, 1);
    tick();
    chk("r_no_done", done, 0);
    chk("r_no_fail", fail, 0);
    chk("r_busy", busy, 1);
    tick();
    chk("r_gap_go", prgrm_go_, 1);
    chk("r_gap_in", prgrm_in, 0);
    frame(8'h3C, "r2");
    tick();
    chk("r2_done_early", done, 0);
    tick();
    chk("r2_done", done, 1);
    chk("r2_fail", fail, 0);
    chk("r2_busy", busy, 0);
    tick();

    // Permanent error -> 1 + 3 frames, then fail.
    err_ = 1'b0;
    accept(8'hFF);
    frames = 0;
    dones = 0;
    fails = 0;
    go_prev = prgrm_go_;
    for (int e = 0; e < 100; e++) begin
      tick();
      if (go_prev && !prgrm_go_) frames++;
      go_prev = prgrm_go_;
      if (done) dones++;
      if (fail) begin
        fails++;
        chk("f_busy_fall", busy, 0);
        break;
      end
    end
    tick();
    chk("f_frames", frames, 4);
    chk("f_fail_count", fails, 1);
    chk("f_done_count", dones, 0);
    chk("f_fail_single", fail, 0);
    chk("f_ready_back", cfg_ready, 1);
    err_ = 1'b1;

    // Reset during bit 3 of a frame.
    accept(8'hA5);
    for (int k = 0; k < 4; k++) tick();
    chk("m_bit3_go", prgrm_go_, 0);
    rst_ = 1'b0;
    tick();
    chk("m_go", prgrm_go_, 1);
    chk("m_in", prgrm_in, 0);
    chk("m_busy", busy, 0);
    chk("m_done", done, 0);
    chk("m_fail", fail, 0);
    chk("m_ready", cfg_ready, 0);
    rst_ = 1'b1;
    tick();
    chk("m_ready_back", cfg_ready, 1);
    run_word('{8'h01, 8'b0000_0001, 1'b1, DONE_EDGE});

    // cfg_valid ignored while busy.
    accept(8'h81);
    cfg_valid = 1'b1;
    cfg_data = 8'h00;
    frame(8'h81, "ib");
    cfg_valid = 1'b0;
    tick();
    tick();
    chk("ib_done", done, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
